// File: rtl/fifo_burst_reader.sv
// Purpose : pops a burst of burst_len_i words from an async FIFO read port and streams them out with m_last_o.
// Latency : a word popped at edge N is presented on m_valid_o/m_data_o right after edge N.
// Backpr. : 2-entry output buffer, 1 word/clk sustained; popping stalls once it is full, with no comb path m_ready_i -> rinc_o.
//
// Ports (all synchronous to rclk_i):
//   rrst_i                  synchronous active-high reset
//   start_i, burst_len_i    burst request (sampled only while idle)
//   busy_o, done_o          burst in flight / 1-cycle completion pulse
//   words_cnt_o             words popped in the current or last burst
//   rempty_i, rdata_i       FIFO read side: empty flag and head word
//   rinc_o                  FIFO pop strobe
//   m_valid_o/m_ready_i     downstream handshake
//   m_data_o, m_last_o      downstream word and end-of-burst marker
module fifo_burst_reader #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          rclk_i,
  input  logic          rrst_i,
  input  logic          start_i,
  input  logic [CW-1:0] burst_len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] words_cnt_o,
  input  logic          rempty_i,
  input  logic [DW-1:0] rdata_i,
  output logic          rinc_o,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  output logic          m_last_o,
  input  logic          m_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // One output-buffer slot: the word plus its end-of-burst flag.
  typedef struct packed {
    logic          last;
    logic [DW-1:0] dat;
  } ent_t;

  state_e        state_q, state_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [CW-1:0] words_cnt_q, words_cnt_d;
  ent_t          ent0_q, ent0_d;   // head slot, drives the stream outputs
  ent_t          ent1_q, ent1_d;
  logic [1:0]    buf_cnt_q, buf_cnt_d;

  logic          rinc;
  logic          pop;
  logic          start_ok;
  ent_t          new_ent;

  // Pop decision uses only registered state and the FIFO flag, so m_ready_i
  // never reaches rinc_o combinationally.
  assign pop      = (buf_cnt_q != 2'd0) && m_ready_i;
  assign start_ok = (state_q == S_IDLE) && start_i;
  assign new_ent  = '{last: (remaining_q == CW'(1)), dat: rdata_i};

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge rclk_i) begin
    if (rrst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (burst_len_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Leave RUN on the edge that pops the final word.
        if ((rinc && (remaining_q == CW'(1))) || (remaining_q == '0)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && ent0_q.last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    rinc   = (state_q == S_RUN) && !rempty_i && (remaining_q != '0) && (buf_cnt_q < 2'd2);
    busy_o = (state_q == S_RUN) || (state_q == S_DRAIN);
    done_o = (state_q == S_DONE);
  end

  assign rinc_o = rinc;

  // ---------------------------------------------------------------- counters and output buffer
  always_comb begin
    remaining_d = remaining_q;
    words_cnt_d = words_cnt_q;
    ent0_d      = ent0_q;
    ent1_d      = ent1_q;
    buf_cnt_d   = buf_cnt_q;

    if (start_ok) begin
      remaining_d = burst_len_i;
      words_cnt_d = '0;
    end else if (rinc) begin
      // rinc implies remaining_q != 0, so the decrement cannot wrap.
      remaining_d = remaining_q - CW'(1);
      if (words_cnt_q != {CW{1'b1}}) begin
        words_cnt_d = words_cnt_q + CW'(1);
      end
    end

    unique case ({rinc, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) begin
          ent0_d = new_ent;
        end else begin
          ent1_d = new_ent;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d    = ent1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        // Push only happens below 2 entries, so here buf_cnt_q is 1.
        ent0_d = new_ent;
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk_i) begin
    if (rrst_i) begin
      remaining_q <= '0;
      words_cnt_q <= '0;
      ent0_q      <= '0;
      ent1_q      <= '0;
      buf_cnt_q   <= 2'd0;
    end else begin
      remaining_q <= remaining_d;
      words_cnt_q <= words_cnt_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      buf_cnt_q   <= buf_cnt_d;
    end
  end

  assign words_cnt_o = words_cnt_q;
  assign m_valid_o   = (buf_cnt_q != 2'd0);
  assign m_data_o    = ent0_q.dat;
  assign m_last_o    = ent0_q.last && (buf_cnt_q != 2'd0);

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rrst, start, rempty, m_ready;
  logic [CW-1:0] burst_len;
  logic [DW-1:0] rdata;
  logic          busy, done, rinc, m_valid, m_last;
  logic [CW-1:0] words_cnt;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DW(DW), .CW(CW)) dut (
    .rclk_i(clk), .rrst_i(rrst), .start_i(start), .burst_len_i(burst_len),
    .busy_o(busy), .done_o(done), .words_cnt_o(words_cnt),
    .rempty_i(rempty), .rdata_i(rdata), .rinc_o(rinc),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last), .m_ready_i(m_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural source FIFO: contents in a queue, head popped after each pop edge.
  logic [DW-1:0] fifo_q[$];
  logic          rinc_pend = 1'b0;

  task automatic fifo_refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic fifo_write(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_refresh();
  endtask

  always @(posedge clk) begin
    #1;
    if (rinc_pend === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_refresh();
  end

  // Observer: records what happened each cycle, sampled mid-cycle.
  int            cyc = 0;
  int            rinc_cnt, rinc_first, rinc_last, done_cnt, done_cyc, last_hs_cyc, first_vld_cyc, stab_viol;
  logic          busy_at_done;
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    cyc++;
    rinc_pend = rinc;
    if (rinc === 1'b1) begin
      if (rinc_cnt == 0) rinc_first = cyc;
      rinc_last = cyc;
      rinc_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (m_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (pv && !pr && rrst === 1'b0 && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) stab_viol++;
    if (m_valid === 1'b1 && m_ready === 1'b1 && rrst === 1'b0) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
      if (m_last === 1'b1) last_hs_cyc = cyc;
    end
    pv = (m_valid === 1'b1) && (rrst === 1'b0);
    pr = (m_ready === 1'b1);
    pd = m_data;
    pl = m_last;
  end

  task automatic mon_clear();
    rinc_cnt = 0; rinc_first = -1; rinc_last = -1; done_cnt = 0; done_cyc = -1;
    last_hs_cyc = -1; first_vld_cyc = -1; stab_viol = 0; busy_at_done = 1'bx;
    got_d.delete(); got_l.delete();
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic start_burst(input int n);
    burst_len = CW'(n);
    start     = 1'b1;
    next_cyc();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int i = 0;
    ok = 0;
    while (!ok && i < budget) begin
      if (done_cnt > 0) ok = 1;
      else begin next_cyc(); i++; end
    end
  endtask

  // ---------------------------------------------------------------- T1
  task automatic test_reset();
    rrst = 1'b1;
    next_cyc(); next_cyc();
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL por_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL por_done: got %b want 0", done); end
    n_cmp++; if (rinc !== 1'b0)      begin n_bad++; $display("FAIL por_rinc: got %b want 0", rinc); end
    n_cmp++; if (m_valid !== 1'b0)   begin n_bad++; $display("FAIL por_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_last !== 1'b0)    begin n_bad++; $display("FAIL por_m_last: got %b want 0", m_last); end
    n_cmp++; if (words_cnt !== '0)   begin n_bad++; $display("FAIL por_words_cnt: got %0d want 0", words_cnt); end
    n_cmp++; if (m_data !== '0)      begin n_bad++; $display("FAIL por_m_data: got %h want 0", m_data); end
    rrst = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(DW'($urandom));
    m_ready = 1'b0;
    start_burst(4);
    next_cyc(); next_cyc();
    rrst = 1'b1;
    next_cyc();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || rinc !== 1'b0)
      begin n_bad++; $display("FAIL rst_ctrl: busy/done/rinc got %b%b%b want 000", busy, done, rinc); end
    n_cmp++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0)
      begin n_bad++; $display("FAIL rst_stream: valid/last/data got %b%b %h want 00 00", m_valid, m_last, m_data); end
    n_cmp++; if (words_cnt !== '0)   begin n_bad++; $display("FAIL rst_words_cnt: got %0d want 0", words_cnt); end
    next_cyc();
    rrst = 1'b0;
    mon_clear();
    repeat (4) next_cyc();
    n_cmp++; if (rinc_cnt !== 0)     begin n_bad++; $display("FAIL rst_no_rinc: got %0d pops want 0", rinc_cnt); end
    fifo_q.delete(); fifo_refresh();
  endtask

  // ---------------------------------------------------------------- T2
  task automatic test_basic();
    bit ok;
    for (int i = 0; i < 8; i++) fifo_write(DW'(i));
    m_ready = 1'b1;
    mon_clear();
    start_burst(5);
    wait_done(40, ok);
    next_cyc();
    n_cmp++; if (!ok)                begin n_bad++; $display("FAIL basic_done_timeout: got no done want done"); end
    n_cmp++; if (rinc_cnt != 5 || rinc_last - rinc_first != 4)
      begin n_bad++; $display("FAIL basic_rinc: got %0d pops over %0d cycles want 5 consecutive", rinc_cnt, rinc_last - rinc_first + 1); end
    n_cmp++; if (got_d.size() != 5)  begin n_bad++; $display("FAIL basic_count: got %0d words want 5", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 5; i++) begin
      n_cmp++; if (got_d[i] !== DW'(i) || got_l[i] !== (i == 4))
        begin n_bad++; $display("FAIL basic_word%0d: got %h/last %b want %h/last %b", i, got_d[i], got_l[i], DW'(i), i == 4); end
    end
    n_cmp++; if (first_vld_cyc != rinc_first + 1)
      begin n_bad++; $display("FAIL basic_latency: got valid cycle %0d want %0d", first_vld_cyc, rinc_first + 1); end
    n_cmp++; if (done_cnt != 1 || done_cyc != last_hs_cyc + 1 || busy_at_done !== 1'b0)
      begin n_bad++; $display("FAIL basic_done: got %0d pulses at %0d busy %b want 1 at %0d busy 0", done_cnt, done_cyc, busy_at_done, last_hs_cyc + 1); end
    n_cmp++; if (words_cnt !== CW'(5)) begin n_bad++; $display("FAIL basic_words_cnt: got %0d want 5", words_cnt); end
    n_cmp++; if (fifo_q.size() != 3) begin n_bad++; $display("FAIL basic_left: got %0d words want 3", fifo_q.size()); end
    fifo_q.delete(); fifo_refresh();
  endtask

  // ---------------------------------------------------------------- T3
  task automatic test_backpressure();
    bit ok = 0;
    logic [DW-1:0] exp_q[$];
    for (int i = 0; i < 8; i++) fifo_write(DW'($urandom));
    exp_q = fifo_q;
    m_ready = 1'b0;
    mon_clear();
    start_burst(6);
    repeat (10) next_cyc();
    n_cmp++; if (rinc_cnt != 2)      begin n_bad++; $display("FAIL bp_stall_pops: got %0d want 2", rinc_cnt); end
    n_cmp++; if (m_valid !== 1'b1 || m_data !== exp_q[0])
      begin n_bad++; $display("FAIL bp_head: got valid %b data %h want 1 %h", m_valid, m_data, exp_q[0]); end
    n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL bp_busy: got %b want 1", busy); end
    for (int i = 0; i < 300 && !ok; i++) begin
      m_ready = ($urandom_range(0, 1) == 1);
      next_cyc();
      ok = (done_cnt > 0);
    end
    m_ready = 1'b1;
    n_cmp++; if (!ok)                begin n_bad++; $display("FAIL bp_done_timeout: got no done want done"); end
    n_cmp++; if (got_d.size() != 6)  begin n_bad++; $display("FAIL bp_count: got %0d words want 6", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 6; i++) begin
      n_cmp++; if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 5))
        begin n_bad++; $display("FAIL bp_word%0d: got %h/last %b want %h/last %b", i, got_d[i], got_l[i], exp_q[i], i == 5); end
    end
    n_cmp++; if (stab_viol != 0)     begin n_bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_viol); end
    n_cmp++; if (fifo_q.size() != 2) begin n_bad++; $display("FAIL bp_left: got %0d words want 2", fifo_q.size()); end
    fifo_q.delete(); fifo_refresh();
  endtask

  // ---------------------------------------------------------------- T4
  task automatic test_underflow();
    bit ok;
    logic [DW-1:0] exp_q[$];
    for (int i = 0; i < 3; i++) fifo_write(DW'($urandom));
    m_ready = 1'b1;
    mon_clear();
    start_burst(6);
    repeat (12) next_cyc();
    n_cmp++; if (rinc_cnt != 3 || busy !== 1'b1 || done_cnt != 0)
      begin n_bad++; $display("FAIL uf_stall: got pops %0d busy %b done %0d want 3 1 0", rinc_cnt, busy, done_cnt); end
    exp_q = got_d;
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] w = DW'($urandom);
      exp_q.push_back(w);
      fifo_write(w);
      next_cyc();
    end
    wait_done(40, ok);
    n_cmp++; if (!ok)                begin n_bad++; $display("FAIL uf_done_timeout: got no done want done"); end
    n_cmp++; if (got_d.size() != 6)  begin n_bad++; $display("FAIL uf_count: got %0d words want 6", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 6; i++) begin
      n_cmp++; if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 5))
        begin n_bad++; $display("FAIL uf_word%0d: got %h/last %b want %h/last %b", i, got_d[i], got_l[i], exp_q[i], i == 5); end
    end
    n_cmp++; if (words_cnt !== CW'(6)) begin n_bad++; $display("FAIL uf_words_cnt: got %0d want 6", words_cnt); end
    next_cyc();
  endtask

  // ---------------------------------------------------------------- T5
  task automatic test_zero_and_ignore();
    bit ok;
    fifo_q.delete();
    for (int i = 0; i < 4; i++) fifo_write(DW'($urandom));
    mon_clear();
    start_burst(0);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0)
      begin n_bad++; $display("FAIL zero_done: got done %b busy %b want 1 0", done, busy); end
    next_cyc();
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL zero_pulse: got done %b want 0", done); end
    repeat (3) next_cyc();
    n_cmp++; if (rinc_cnt != 0 || words_cnt !== '0)
      begin n_bad++; $display("FAIL zero_no_pop: got pops %0d words_cnt %0d want 0 0", rinc_cnt, words_cnt); end
    m_ready = 1'b0;
    mon_clear();
    start_burst(2);
    repeat (3) next_cyc();
    start_burst(1);
    m_ready = 1'b1;
    wait_done(30, ok);
    repeat (5) next_cyc();
    n_cmp++; if (!ok)                begin n_bad++; $display("FAIL ign_done_timeout: got no done want done"); end
    n_cmp++; if (done_cnt != 1 || got_d.size() != 2 || rinc_cnt != 2)
      begin n_bad++; $display("FAIL ign_start: got done %0d words %0d pops %0d want 1 2 2", done_cnt, got_d.size(), rinc_cnt); end
    n_cmp++; if (fifo_q.size() != 2) begin n_bad++; $display("FAIL ign_left: got %0d words want 2", fifo_q.size()); end
    fifo_q.delete(); fifo_refresh();
  endtask

  // ---------------------------------------------------------------- T6
  task automatic test_mid_reset();
    bit ok;
    int i = 0;
    logic [DW-1:0] snap[$];
    for (int k = 0; k < 8; k++) fifo_write(DW'($urandom));
    m_ready = 1'b1;
    mon_clear();
    start_burst(6);
    while (got_d.size() < 2 && i < 20) begin next_cyc(); i++; end
    n_cmp++; if (got_d.size() < 2)   begin n_bad++; $display("FAIL mrst_progress: got %0d words want 2", got_d.size()); end
    rrst = 1'b1;
    next_cyc();
    n_cmp++; if (busy !== 1'b0 || m_valid !== 1'b0 || rinc !== 1'b0 || words_cnt !== '0)
      begin n_bad++; $display("FAIL mrst_outputs: got busy %b valid %b rinc %b cnt %0d want 0 0 0 0", busy, m_valid, rinc, words_cnt); end
    rrst = 1'b0;
    next_cyc();
    snap = fifo_q;
    mon_clear();
    start_burst(3);
    wait_done(30, ok);
    n_cmp++; if (!ok)                begin n_bad++; $display("FAIL mrst_done_timeout: got no done want done"); end
    n_cmp++; if (got_d.size() != 3 || snap.size() < 3)
      begin n_bad++; $display("FAIL mrst_count: got %0d words (fifo had %0d) want 3", got_d.size(), snap.size()); end
    else for (int k = 0; k < 3; k++) begin
      n_cmp++; if (got_d[k] !== snap[k] || got_l[k] !== (k == 2))
        begin n_bad++; $display("FAIL mrst_word%0d: got %h/last %b want %h/last %b", k, got_d[k], got_l[k], snap[k], k == 2); end
    end
    n_cmp++; if (words_cnt !== CW'(3)) begin n_bad++; $display("FAIL mrst_words_cnt: got %0d want 3", words_cnt); end
    next_cyc();
    fifo_q.delete(); fifo_refresh();
  endtask

  // ---------------------------------------------------------------- randomized back-to-back bursts
  task automatic test_random();
    logic [DW-1:0] stream[$];
    int consumed = 0;
    for (int b = 0; b < 8; b++) begin
      bit ok = 0;
      int n = $urandom_range(1, 12);
      mon_clear();
      start_burst(n);
      for (int c = 0; c < 400 && !ok; c++) begin
        m_ready = ($urandom_range(0, 3) != 0);
        if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) begin
          logic [DW-1:0] w = DW'($urandom);
          stream.push_back(w);
          fifo_write(w);
        end
        next_cyc();
        ok = (done_cnt > 0);
      end
      n_cmp++; if (!ok)              begin n_bad++; $display("FAIL rnd%0d_done_timeout: got no done want done", b); end
      n_cmp++; if (got_d.size() != n || rinc_cnt != n || words_cnt !== CW'(n))
        begin n_bad++; $display("FAIL rnd%0d_count: got words %0d pops %0d cnt %0d want %0d", b, got_d.size(), rinc_cnt, words_cnt, n); end
      else for (int k = 0; k < n; k++) begin
        n_cmp++; if (got_d[k] !== stream[consumed + k] || got_l[k] !== (k == n - 1))
          begin n_bad++; $display("FAIL rnd%0d_word%0d: got %h/last %b want %h/last %b", b, k, got_d[k], got_l[k], stream[consumed + k], k == n - 1); end
      end
      consumed += n;
      n_cmp++; if (stab_viol != 0)   begin n_bad++; $display("FAIL rnd%0d_stable: got %0d changes want 0", b, stab_viol); end
      next_cyc();
      n_cmp++; if (fifo_q.size() != stream.size() - consumed)
        begin n_bad++; $display("FAIL rnd%0d_left: got %0d words want %0d", b, fifo_q.size(), stream.size() - consumed); end
    end
    m_ready = 1'b1;
  endtask

  initial begin
    rrst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
    fifo_refresh();
    mon_clear();
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_zero_and_ignore();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
